// File: rtl/nr_mult_rom_core.sv
// Newton-Raphson reciprocal support: seed ROM plus two fixed one-stage multiplier pipelines.
// Define NR_ROM_REG_EN to register rom_data (one cycle latency, resets to zero).
module nr_mult_rom_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  rom_addr,
    output logic [14:0] rom_data,
    input  logic [15:0] m1_a,
    input  logic [15:0] m1_b,
    input  logic        m1_in_valid,
    output logic [31:0] m1_p,
    output logic        m1_valid,
    input  logic [15:0] m2_a,
    input  logic [31:0] m2_b,
    input  logic        m2_in_valid,
    output logic [23:0] m2_p,
    output logic        m2_valid
);

    localparam int unsigned ROM_DEPTH = 64;
    localparam int unsigned ROM_W     = 15;
    localparam int unsigned TBL_W     = ROM_DEPTH * ROM_W;
    localparam int unsigned M1_W      = 32;
    localparam int unsigned M2_W      = 24;
    localparam int unsigned M2_FULL_W = 48;
    localparam int unsigned M2_SHIFT  = 23;

    // Seed for the interval midpoint xm = (129+2a)/256: 32768*(127-2a)/(129+2a), rounded half-up.
    function automatic logic [TBL_W-1:0] build_seed_table();
        logic [TBL_W-1:0] tbl;
        int unsigned      num;
        int unsigned      den;
        int unsigned      quo;
        tbl = '0;
        for (int unsigned a = 0; a < ROM_DEPTH; a++) begin
            den = 32'd129 + 32'd2 * a;
            num = 32'd65536 * (32'd127 - 32'd2 * a) + den;
            quo = num / (32'd2 * den);
            if (quo > 32'd32767) begin
                quo = 32'd32767;
            end
            tbl[a*ROM_W +: ROM_W] = ROM_W'(quo);
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] SEED_TABLE = build_seed_table();

    logic [ROM_W-1:0] rom_data_c;

    always_comb begin
        rom_data_c = SEED_TABLE[32'(rom_addr) * ROM_W +: ROM_W];
    end

`ifdef NR_ROM_REG_EN
    logic [ROM_W-1:0] rom_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_data_q <= '0;
        end else begin
            rom_data_q <= rom_data_c;
        end
    end

    assign rom_data = rom_data_q;
`else
    assign rom_data = rom_data_c;
`endif

    // Multiplier 1: exact 16x16 unsigned product, held while idle.
    logic [M1_W-1:0] m1_p_d;
    logic [M1_W-1:0] m1_p_q;
    logic            m1_valid_q;

    always_comb begin
        m1_p_d = m1_p_q;
        if (m1_in_valid) begin
            m1_p_d = M1_W'(m1_a) * M1_W'(m1_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_p_q     <= '0;
            m1_valid_q <= 1'b0;
        end else begin
            m1_p_q     <= m1_p_d;
            m1_valid_q <= m1_in_valid;
        end
    end

    // Multiplier 2: Q1.15 x Q1.31 -> Q1.23, truncated, saturating when the integer part reaches 2.
    logic [M2_W:0]   m2_hi_c;
    logic [M2_W-1:0] m2_p_d;
    logic [M2_W-1:0] m2_p_q;
    logic            m2_valid_q;

    always_comb begin
        m2_hi_c = (M2_W+1)'((M2_FULL_W'(m2_a) * M2_FULL_W'(m2_b)) >> M2_SHIFT);
        m2_p_d  = m2_p_q;
        if (m2_in_valid) begin
            m2_p_d = m2_hi_c[M2_W] ? {M2_W{1'b1}} : m2_hi_c[M2_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_p_q     <= '0;
            m2_valid_q <= 1'b0;
        end else begin
            m2_p_q     <= m2_p_d;
            m2_valid_q <= m2_in_valid;
        end
    end

    assign m1_p     = m1_p_q;
    assign m1_valid = m1_valid_q;
    assign m2_p     = m2_p_q;
    assign m2_valid = m2_valid_q;

endmodule

// File: tb/tb_nr_mult_rom_core.sv
// Directed bench for nr_mult_rom_core: reset, seed ROM sweep, both multipliers, streaming.
module tb_nr_mult_rom_core;

    logic        clk;
    logic        rst_n;
    logic [5:0]  rom_addr;
    logic [14:0] rom_data;
    logic [15:0] m1_a;
    logic [15:0] m1_b;
    logic        m1_in_valid;
    logic [31:0] m1_p;
    logic        m1_valid;
    logic [15:0] m2_a;
    logic [31:0] m2_b;
    logic        m2_in_valid;
    logic [23:0] m2_p;
    logic        m2_valid;

    int total;
    int bad;

    nr_mult_rom_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .m1_a        (m1_a),
        .m1_b        (m1_b),
        .m1_in_valid (m1_in_valid),
        .m1_p        (m1_p),
        .m1_valid    (m1_valid),
        .m2_a        (m2_a),
        .m2_b        (m2_b),
        .m2_in_valid (m2_in_valid),
        .m2_p        (m2_p),
        .m2_valid    (m2_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference seed from the midpoint formula, evaluated in floating point.
    function automatic int seed_ref(input int a);
        real xm;
        real v;
        int  r;
        xm = 0.5 + (real'(a) + 0.5) / 128.0;
        v  = 32768.0 * (1.0 / xm - 1.0);
        r  = $rtoi(v + 0.5);
        if (r > 32767) r = 32767;
        return r;
    endfunction

    task automatic rom_read(input logic [5:0] a);
        rom_addr = a;
`ifdef NR_ROM_REG_EN
        step();
`else
        #1;
`endif
    endtask

    task automatic m1_drive(input logic v, input logic [15:0] a, input logic [15:0] b);
        m1_in_valid = v;
        m1_a        = a;
        m1_b        = b;
    endtask

    task automatic m2_drive(input logic v, input logic [15:0] a, input logic [31:0] b);
        m2_in_valid = v;
        m2_a        = a;
        m2_b        = b;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rom_addr = 6'd0;
        m1_drive(1'b0, 16'd0, 16'd0);
        m2_drive(1'b0, 16'd0, 32'd0);

        #2;
        chk("rst_m1_p", m1_p, 32'd0);
        chk("rst_m1_valid", 32'(m1_valid), 32'd0);
        chk("rst_m2_p", 32'(m2_p), 32'd0);
        chk("rst_m2_valid", 32'(m2_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Seed ROM endpoints and full sweep
        rom_read(6'd0);
        chk("rom_a0", 32'(rom_data), 32'h7E04);
        rom_read(6'd63);
        chk("rom_a63", 32'(rom_data), 32'h0081);
        for (int a = 0; a < 64; a++) begin
            rom_read(6'(a));
            chk($sformatf("rom_sweep_%0d", a), 32'(rom_data), 32'(seed_ref(a)));
        end

        // Multiplier 1 maximum operands, then idle hold
        m1_drive(1'b1, 16'hFFFF, 16'hFFFF);
        step();
        chk("m1_max_p", m1_p, 32'hFFFE0001);
        chk("m1_max_valid", 32'(m1_valid), 32'd1);
        m1_drive(1'b0, 16'h1234, 16'h5678);
        step();
        chk("m1_idle_p", m1_p, 32'hFFFE0001);
        chk("m1_idle_valid", 32'(m1_valid), 32'd0);
        m1_drive(1'b1, 16'h1234, 16'h5678);
        step();
        chk("m1_mid_p", m1_p, 32'h0626_0060);

        // Multiplier 2 directed points
        m1_drive(1'b0, 16'd0, 16'd0);
        m2_drive(1'b1, 16'h8000, 32'h8000_0000);
        step();
        chk("m2_one_p", 32'(m2_p), 32'h80_0000);
        chk("m2_one_valid", 32'(m2_valid), 32'd1);
        m2_drive(1'b1, 16'hFFFF, 32'hFFFF_FFFF);
        step();
        chk("m2_sat_max", 32'(m2_p), 32'hFF_FFFF);
        m2_drive(1'b1, 16'hC000, 32'hC000_0000);
        step();
        chk("m2_sat_2p25", 32'(m2_p), 32'hFF_FFFF);
        m2_drive(1'b1, 16'h4000, 32'h4000_0000);
        step();
        chk("m2_quarter", 32'(m2_p), 32'h20_0000);
        m2_drive(1'b1, 16'h8001, 32'h8000_0000);
        step();
        chk("m2_trunc", 32'(m2_p), 32'h80_0100);
        m2_drive(1'b0, 16'h1111, 32'h1111_1111);
        step();
        chk("m2_idle_p", 32'(m2_p), 32'h80_0100);
        chk("m2_idle_valid", 32'(m2_valid), 32'd0);

        // Both multipliers in the same cycle
        m1_drive(1'b1, 16'd300, 16'd400);
        m2_drive(1'b1, 16'h8000, 32'h4000_0000);
        step();
        chk("dual_m1_p", m1_p, 32'd120000);
        chk("dual_m1_valid", 32'(m1_valid), 32'd1);
        chk("dual_m2_p", 32'(m2_p), 32'h40_0000);
        chk("dual_m2_valid", 32'(m2_valid), 32'd1);

        // Streaming 1,1,0,1 on multiplier 1
        m2_drive(1'b0, 16'd0, 32'd0);
        m1_drive(1'b1, 16'd3, 16'd5);
        step();
        chk("strm0_valid", 32'(m1_valid), 32'd1);
        chk("strm0_p", m1_p, 32'd15);
        m1_drive(1'b1, 16'd7, 16'd11);
        step();
        chk("strm1_valid", 32'(m1_valid), 32'd1);
        chk("strm1_p", m1_p, 32'd77);
        m1_drive(1'b0, 16'd100, 16'd100);
        step();
        chk("strm2_valid", 32'(m1_valid), 32'd0);
        chk("strm2_hold", m1_p, 32'd77);
        m1_drive(1'b1, 16'd13, 16'd17);
        step();
        chk("strm3_valid", 32'(m1_valid), 32'd1);
        chk("strm3_p", m1_p, 32'd221);

        // Asynchronous reset mid-stream, no clock edge in between
        m1_drive(1'b1, 16'd9, 16'd9);
        m2_drive(1'b1, 16'h8000, 32'h8000_0000);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m1_p", m1_p, 32'd0);
        chk("arst_m1_valid", 32'(m1_valid), 32'd0);
        chk("arst_m2_p", 32'(m2_p), 32'd0);
        chk("arst_m2_valid", 32'(m2_valid), 32'd0);
`ifdef NR_ROM_REG_EN
        chk("arst_rom", 32'(rom_data), 32'd0);
`endif

        // First edge after release with in_valid high yields a result
        #1;
        rst_n = 1'b1;
        m1_drive(1'b1, 16'd6, 16'd7);
        m2_drive(1'b1, 16'h4000, 32'h8000_0000);
        step();
        chk("post_rst_m1_valid", 32'(m1_valid), 32'd1);
        chk("post_rst_m1_p", m1_p, 32'd42);
        chk("post_rst_m2_valid", 32'(m2_valid), 32'd1);
        chk("post_rst_m2_p", 32'(m2_p), 32'h40_0000);

        m1_drive(1'b0, 16'd0, 16'd0);
        m2_drive(1'b0, 16'd0, 32'd0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
